sequential_trojan: RTL

Parametrised, sequence-triggered hardware-trojan benchmark for the hardware-security test suite. It sits on a sampled data path. The block performs three functions:
- It encodes each valid input word to a leading-one bucket.
- It registers the bucket into a capture register beside a reference register.
- It reports equality of the two registers.

A hidden FSM watches the masked input for a programmed multi-step pattern sequence. On completion it forces the capture register to the reference value for a fixed number of samples, producing false matches.

---
 rtl/sequential_trojan.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sequential_trojan.sv
// Sequence-triggered trojan benchmark: leading-one encoder feeding a capture/reference compare,
// with a hidden FSM that forces false matches after a programmed input pattern sequence.
module sequential_trojan #(
  parameter int unsigned              W           = 10,
  parameter int unsigned              EW          = $clog2(W + 1),
  parameter int unsigned              TRIG_LEN    = 3,
  parameter logic [W-1:0]             TRIG_MASK   = 10'h00F,
  parameter logic [TRIG_LEN*W-1:0]    TRIG_SEQ    = 30'h00B0140B,
  parameter int unsigned              PAYLOAD_CYC = 4
) (
  input  logic          c,
  input  logic          rst,
  input  logic [W-1:0]  i,
  input  logic          in_valid,
  input  logic          ref_load,
  output logic          res,
  output logic          res_valid,
  output logic [EW-1:0] q,
  output logic [EW-1:0] Q,
  output logic          armed,
  output logic          payload_active
);

  localparam int unsigned SW = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;
  localparam int unsigned CW = (PAYLOAD_CYC > 1) ? $clog2(PAYLOAD_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StTrack, StFire} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] q_q, q_d;
  logic [EW-1:0] ref_q, ref_d;
  logic          res_valid_q;

  logic [EW-1:0] enc;
  logic          hit;
  logic          sel;
  logic          m_step;
  logic          m_first;
  logic [W-1:0]  pat [TRIG_LEN];

  for (genvar k = 0; k < TRIG_LEN; k++) begin : g_pat
    assign pat[k] = TRIG_SEQ[k*W +: W];
  end

  assign m_step  = ((i & TRIG_MASK) == (pat[step_q] & TRIG_MASK));
  assign m_first = ((i & TRIG_MASK) == (pat[0] & TRIG_MASK));

  // Leading-one bucket: 0 for zero input, else index of highest set bit plus one.
  always_comb begin
    enc = '0;
    for (int k = 0; k < W; k++) begin
      if (i[k]) begin
        enc = EW'(k + 1);
      end
    end
  end

  // State register.
  always_ff @(posedge c) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt holds the FIRE samples still to corrupt after the completing one.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    hit     = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        StIdle, StTrack: begin
          if (m_step && (step_q == SW'(TRIG_LEN - 1))) begin
            hit    = 1'b1;
            step_d = '0;
            if (PAYLOAD_CYC > 1) begin
              state_d = StFire;
              cnt_d   = CW'(PAYLOAD_CYC - 1);
            end else begin
              state_d = StIdle;
            end
          end else if (m_step) begin
            step_d  = step_q + 1'b1;
            state_d = StTrack;
          end else if (m_first) begin
            step_d  = SW'(1);
            state_d = StTrack;
          end else begin
            step_d  = '0;
            state_d = StIdle;
          end
        end
        StFire: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          step_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode.
  always_comb begin
    armed          = (state_q != StIdle);
    payload_active = (state_q == StFire);
    sel            = hit | (state_q == StFire);
  end

  always_comb begin
    q_d   = q_q;
    ref_d = ref_q;
    if (in_valid) begin
      q_d = sel ? ref_q : enc;
      if (ref_load) begin
        ref_d = enc;
      end
    end
  end

  always_ff @(posedge c) begin
    if (rst) begin
      q_q         <= '0;
      ref_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      ref_q       <= ref_d;
      res_valid_q <= in_valid;
    end
  end

  assign q         = q_q;
  assign Q         = ref_q;
  assign res_valid = res_valid_q;
  assign res       = res_valid_q & (q_q == ref_q);

endmodule
